// File: rtl/fft_dma_reader.sv
// Sequential DMA read engine for the FFT working RAM: walks every word (optionally
// bit-reversed) and presents it as a valid/ready stream through a 2-entry skid FIFO.
module fft_dma_reader #(
    parameter int FFT_N       = 10,
    parameter int FFT_DW      = 16,
    parameter int BIT_REVERSE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  ract_dma,
    output logic [FFT_N-2:0]      ra_dma,
    input  logic [2*FFT_DW-1:0]   rdr_dma,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [2*FFT_DW-1:0]   m_data,
    output logic [FFT_N-2:0]      m_index,
    output logic                  m_last
);

    localparam int AW = FFT_N - 1;
    localparam int DW = 2 * FFT_DW;
    localparam logic [AW-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   seq_q, seq_d;
    logic            inflight_q, inflight_d;
    logic [AW-1:0]   infl_idx_q, infl_idx_d;
    logic [DW-1:0]   mem_data_q [2];
    logic [DW-1:0]   mem_data_d [2];
    logic [AW-1:0]   mem_idx_q [2];
    logic [AW-1:0]   mem_idx_d [2];
    logic            rp_q, rp_d, wp_q, wp_d;
    logic [1:0]      count_q, count_d;
    logic            done_q, done_d;

    logic            pop, issue, abort_now;
    logic [1:0]      occ;

    function automatic logic [AW-1:0] f_addr(input logic [AW-1:0] s);
        logic [AW-1:0] r;
        r = s;
        if (BIT_REVERSE != 0) begin
            for (int unsigned i = 0; i < AW; i++) begin
                r[i] = s[AW-1-i];
            end
        end
        return r;
    endfunction

    // A read may issue into a full FIFO only when the head leaves in the same cycle.
    assign pop       = (count_q != 2'd0) && m_ready;
    assign occ       = count_q + {1'b0, inflight_q};
    assign issue     = (state_q == RUN) && ((occ < 2'd2) || ((occ == 2'd2) && pop));
    assign abort_now = abort && (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            seq_q        <= '0;
            inflight_q   <= 1'b0;
            infl_idx_q   <= '0;
            mem_data_q   <= '{default: '0};
            mem_idx_q    <= '{default: '0};
            rp_q         <= 1'b0;
            wp_q         <= 1'b0;
            count_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            inflight_q   <= inflight_d;
            infl_idx_q   <= infl_idx_d;
            mem_data_q   <= mem_data_d;
            mem_idx_q    <= mem_idx_d;
            rp_q         <= rp_d;
            wp_q         <= wp_d;
            count_q      <= count_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        inflight_d = issue;
        infl_idx_d = issue ? seq_q : infl_idx_q;
        mem_data_d = mem_data_q;
        mem_idx_d  = mem_idx_q;
        rp_d       = rp_q;
        wp_d       = wp_q;
        count_d    = count_q + {1'b0, inflight_q} - {1'b0, pop};
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    seq_d   = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    seq_d = seq_q + 1'b1;
                    if (seq_q == LAST_IDX) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (mem_idx_q[rp_q] == LAST_IDX)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (inflight_q) begin
            mem_data_d[wp_q] = rdr_dma;
            mem_idx_d[wp_q]  = infl_idx_q;
            wp_d             = ~wp_q;
        end
        if (pop) rp_d = ~rp_q;

        if (abort_now) begin
            state_d    = IDLE;
            inflight_d = 1'b0;
            rp_d       = 1'b0;
            wp_d       = 1'b0;
            count_d    = '0;
            done_d     = 1'b0;
        end
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = done_q;
        ract_dma = issue;
        ra_dma   = (state_q == RUN) ? f_addr(seq_q) : '0;
        m_valid  = (count_q != 2'd0);
        m_data   = mem_data_q[rp_q];
        m_index  = mem_idx_q[rp_q];
        m_last   = m_valid && (mem_idx_q[rp_q] == LAST_IDX);
    end

endmodule

// File: doc/fft_dma_reader.md
# fft_dma_reader

Sequential read engine that drives the DMA-side read port of the FFT working-RAM read bus multiplexer and turns the RAM contents into a valid/ready output stream. After a start pulse it walks all 2^(FFT_N-1) RAM words, optionally in bit-reversed address order, and absorbs the fixed one-cycle RAM read latency and downstream backpressure with a 2-entry skid FIFO. It is only meaningful while the mux mode is MODE_DMA; mode sequencing is owned by the top-level controller.

## Interface
- FFT_N, 10, log2 of FFT length; RAM depth D = 2^(FFT_N-1) words
- FFT_DW, 16, width of one real/imag component; RAM word = 2*FFT_DW
- BIT_REVERSE, 1, 1: ra_dma is the bit-reverse of the sequence counter; 0: natural order

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  one-cycle pulse, begins a pass; ignored while busy
- abort  in  1  synchronous abort of a running pass
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse after last beat accepted
- ract_dma  out  1  RAM read strobe to mux DMA port
- ra_dma  out  FFT_N-1  RAM read address to mux DMA port
- rdr_dma  in  2*FFT_DW  RAM read data, valid the cycle after ract_dma
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts beat
- m_data  out  2*FFT_DW  RAM word (FIFO head)
- m_index  out  FFT_N-1  natural sequence number of beat (pre-bit-reverse)
- m_last  out  1  beat has m_index == D-1

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: ract_dma=0, ra_dma=0, busy=0. start=1 -> RUN, seq counter=0.
- RUN: issue a read (ract_dma=1, ra_dma=f(seq)) when fifo_count + inflight < 2, or fifo_count + inflight == 2 and a pop (m_valid && m_ready) occurs this cycle. Each issue increments seq; issue with seq == D-1 -> DRAIN.
- inflight: 1-bit flag, set on issue, cleared next cycle when rdr_dma is written into the FIFO tail along with its seq value.
- FIFO: depth 2; push and pop in same cycle allowed at any count; never overflows by the issue rule.
- DRAIN: no issues; when the beat with m_last is accepted -> IDLE and done=1 for one cycle.
- f(seq) = bit-reverse over FFT_N-1 bits of seq when BIT_REVERSE=1, else seq. m_index always carries seq.
- abort (RUN or DRAIN): next cycle state IDLE, FIFO and inflight cleared, m_valid=0, ract_dma=0, done not pulsed. abort in IDLE has no effect; abort and start in same IDLE cycle: start wins.
- m_valid/m_data/m_index/m_last are stable while m_valid && !m_ready.
- Reset (rst_n=0, any time, including mid-pass): state IDLE; busy, done, ract_dma, m_valid, m_last = 0; ra_dma, m_data, m_index = 0; FIFO empty, inflight 0.

## Timing
- start sampled at edge E0; busy and first ract_dma high in cycle after E0 (cycle 1).
- rdr_dma captured at end of cycle 2; m_valid first high cycle 3. Start-to-first-beat latency 3 cycles.
- m_ready held high: one read and one beat per cycle, D beats in cycles 3..D+2, done in cycle D+3, busy low from cycle D+3.
- m_ready low: at most 2 further reads completed into FIFO; reads resume the same cycle m_ready returns high.
- busy: high from cycle 1 through the cycle the last beat is accepted.

## Test plan
- FFT_N=4 (D=8), BIT_REVERSE=0, RAM model word = 0x1000+addr, m_ready=1: start -> ra_dma 0..7 on cycles 1..8, beats 0x1000..0x1007 cycles 3..10, m_last on index 7, done cycle 11.
- Same, BIT_REVERSE=1: ra_dma sequence 0,4,2,6,1,5,3,7; m_index 0..7 in order; m_data = 0x1000+bitrev3(m_index).
- Random m_ready (50%), D=8: every index 0..7 delivered exactly once in order, no beat changes while stalled, ract_dma never issued with fifo_count+inflight==2 and no pop.
- m_ready low from cycle 3 for 10 cycles: exactly 2 beats buffered, ract_dma low, then full-rate resume, total 8 beats.
- abort at cycle 5 with m_ready=0: m_valid and ract_dma 0 from cycle 6, no done; fresh start then delivers all 8 beats from index 0.
- rst_n low asynchronously mid-RUN: all outputs 0 immediately; start pulse while busy ignored (no restart, seq continues).
